// File: rtl/jelly_img_vec_norm.sv
// N-channel vector magnitude stage: pipelined sum of squares with optional
// non-restoring floor-sqrt, data vector and frame sideband delayed to match.
module jelly_img_vec_norm #(
    parameter int USER_WIDTH = 0,
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int USE_VALID  = 0,
    parameter int USE_SQRT   = 0,
    parameter int USER_BITS  = USER_WIDTH > 0 ? USER_WIDTH : 1,
    parameter int ADD_STAGES = CHANNELS > 2 ? $clog2(CHANNELS) : 1,
    parameter int SS_WIDTH   = 2*DATA_WIDTH + $clog2(CHANNELS),
    parameter int NORM_WIDTH = (SS_WIDTH + 1) / 2,
    parameter int LATENCY    = 2 + ADD_STAGES + (USE_SQRT != 0 ? NORM_WIDTH : 0)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cke,

    input  logic                           s_img_line_first,
    input  logic                           s_img_line_last,
    input  logic                           s_img_pixel_first,
    input  logic                           s_img_pixel_last,
    input  logic                           s_img_de,
    input  logic [USER_BITS-1:0]           s_img_user,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_img_data,
    input  logic                           s_img_valid,

    output logic                           m_img_line_first,
    output logic                           m_img_line_last,
    output logic                           m_img_pixel_first,
    output logic                           m_img_pixel_last,
    output logic                           m_img_de,
    output logic [USER_BITS-1:0]           m_img_user,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_img_data,
    output logic [SS_WIDTH-1:0]            m_img_ss,
    output logic [NORM_WIDTH-1:0]          m_img_norm,
    output logic                           m_img_valid
);

    localparam int CW  = CHANNELS * DATA_WIDTH;
    localparam int SBW = 5 + USER_BITS;

    logic [CW-1:0]       data_d [LATENCY];
    logic [CW-1:0]       data_q [LATENCY];
    logic [SBW-1:0]      sb_d   [LATENCY];
    logic [SBW-1:0]      sb_q   [LATENCY];
    logic [LATENCY-1:0]  vld_d;
    logic [LATENCY-1:0]  vld_q;
    logic [SS_WIDTH-1:0] tree_d [ADD_STAGES+1][CHANNELS];
    logic [SS_WIDTH-1:0] tree_q [ADD_STAGES+1][CHANNELS];
    logic [SS_WIDTH-1:0] ss_tree;

    function automatic logic [SS_WIDTH-1:0] square(input logic [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH-1:0]   sx;
        logic signed [2*DATA_WIDTH-1:0] ex;
        logic signed [2*DATA_WIDTH-1:0] p;
        logic [SS_WIDTH-1:0]            r;
        sx = signed'(x);
        ex = (2*DATA_WIDTH)'(sx);
        p  = ex * ex;
        r  = '0;
        r[2*DATA_WIDTH-1:0] = p;
        return r;
    endfunction

    function automatic int level_count(input int l);
        return (CHANNELS + (1 << l) - 1) >> l;
    endfunction

    // Clamped operand indices keep every array access in range; the
    // level_count guards decide which ones actually contribute.
    function automatic int pair_lo(input int j);
        return (2*j < CHANNELS) ? 2*j : 0;
    endfunction

    function automatic int pair_hi(input int j);
        return (2*j + 1 < CHANNELS) ? 2*j + 1 : 0;
    endfunction

    always_comb begin
        data_d[0] = s_img_data;
        sb_d[0]   = {s_img_user, s_img_de, s_img_pixel_last, s_img_pixel_first,
                     s_img_line_last, s_img_line_first};
        for (int i = 1; i < LATENCY; i++) begin
            data_d[i] = data_q[i-1];
            sb_d[i]   = sb_q[i-1];
        end
        vld_d = {vld_q[LATENCY-2:0], s_img_valid};
    end

    // Level 0 holds the squares; each later level halves the operand count,
    // an odd leftover is simply re-registered to keep stage alignment.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            tree_d[0][c] = square(data_q[0][c*DATA_WIDTH +: DATA_WIDTH]);
        end
        for (int l = 1; l <= ADD_STAGES; l++) begin
            for (int j = 0; j < CHANNELS; j++) begin
                tree_d[l][j] = '0;
                if (2*j + 1 < level_count(l-1)) begin
                    tree_d[l][j] = tree_q[l-1][pair_lo(j)] + tree_q[l-1][pair_hi(j)];
                end else if (2*j < level_count(l-1)) begin
                    tree_d[l][j] = tree_q[l-1][pair_lo(j)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
                sb_q[i]   <= '0;
            end
            for (int l = 0; l <= ADD_STAGES; l++) begin
                for (int j = 0; j < CHANNELS; j++) begin
                    tree_q[l][j] <= '0;
                end
            end
        end else if (cke) begin
            data_q <= data_d;
            sb_q   <= sb_d;
            tree_q <= tree_d;
        end
    end

    // Without USE_VALID the valid bit is a plain delay line that reset ignores.
    always_ff @(posedge clk) begin
        if (reset && (USE_VALID != 0)) begin
            vld_q <= '0;
        end else if (cke) begin
            vld_q <= vld_d;
        end
    end

    assign ss_tree = tree_q[ADD_STAGES][0];

    generate
        if (USE_SQRT != 0) begin : g_sqrt
            localparam int RW    = 2*NORM_WIDTH + 3;
            localparam int RAD_W = 2*NORM_WIDTH;

            logic signed [RW-1:0]   rem_in  [NORM_WIDTH];
            logic [NORM_WIDTH-1:0]  root_in [NORM_WIDTH];
            logic [SS_WIDTH-1:0]    ss_in   [NORM_WIDTH];
            logic signed [RW-1:0]   rem_d   [NORM_WIDTH];
            logic signed [RW-1:0]   rem_q   [NORM_WIDTH];
            logic [NORM_WIDTH-1:0]  root_d  [NORM_WIDTH];
            logic [NORM_WIDTH-1:0]  root_q  [NORM_WIDTH];
            logic [SS_WIDTH-1:0]    ssd_d   [NORM_WIDTH];
            logic [SS_WIDTH-1:0]    ssd_q   [NORM_WIDTH];

            function automatic logic [1:0] rad_pair(input logic [SS_WIDTH-1:0] ss, input int i);
                logic [RAD_W-1:0] rad;
                rad = '0;
                rad[SS_WIDTH-1:0] = ss;
                return rad[2*(NORM_WIDTH-1-i) +: 2];
            endfunction

            // Signed remainder is never restored: its sign picks subtract
            // (4q+1) or add (4q+3) on the next step and sets the root bit.
            function automatic logic signed [RW-1:0] nr_rem(input logic signed [RW-1:0] rem,
                                                            input logic [NORM_WIDTH-1:0] root,
                                                            input logic [1:0] pair);
                logic signed [RW-1:0] sh;
                logic signed [RW-1:0] rx;
                sh = {rem[RW-3:0], pair};
                rx = '0;
                rx[NORM_WIDTH+1:0] = {root, 2'b01};
                if (rem[RW-1]) begin
                    rx[1] = 1'b1;
                    return sh + rx;
                end
                return sh - rx;
            endfunction

            function automatic logic [NORM_WIDTH-1:0] next_root(input logic [NORM_WIDTH-1:0] root,
                                                               input logic signed [RW-1:0] rem);
                logic [NORM_WIDTH-1:0] r;
                r    = root << 1;
                r[0] = ~rem[RW-1];
                return r;
            endfunction

            always_comb begin
                rem_in[0]  = '0;
                root_in[0] = '0;
                ss_in[0]   = ss_tree;
                for (int i = 1; i < NORM_WIDTH; i++) begin
                    rem_in[i]  = rem_q[i-1];
                    root_in[i] = root_q[i-1];
                    ss_in[i]   = ssd_q[i-1];
                end
                for (int i = 0; i < NORM_WIDTH; i++) begin
                    rem_d[i]  = nr_rem(rem_in[i], root_in[i], rad_pair(ss_in[i], i));
                    root_d[i] = next_root(root_in[i], rem_d[i]);
                    ssd_d[i]  = ss_in[i];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < NORM_WIDTH; i++) begin
                        rem_q[i]  <= '0;
                        root_q[i] <= '0;
                        ssd_q[i]  <= '0;
                    end
                end else if (cke) begin
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    ssd_q  <= ssd_d;
                end
            end

            assign m_img_ss   = ssd_q[NORM_WIDTH-1];
            assign m_img_norm = root_q[NORM_WIDTH-1];
        end else begin : g_no_sqrt
            assign m_img_ss   = ss_tree;
            assign m_img_norm = '0;
        end
    endgenerate

    assign m_img_data  = data_q[LATENCY-1];
    assign m_img_valid = vld_q[LATENCY-1];
    assign {m_img_user, m_img_de, m_img_pixel_last, m_img_pixel_first,
            m_img_line_last, m_img_line_first} = sb_q[LATENCY-1];

endmodule

// File: tb/tb_jelly_img_vec_norm.sv
// Bench for jelly_img_vec_norm: scoreboarded two-channel sqrt instance plus
// directed checks on a three-channel and a single-channel instance.
module tb_jelly_img_vec_norm;

    localparam int A_LAT = 12;
    localparam int B_LAT = 4;
    localparam int C_LAT = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cke;
    logic        line_first, line_last, pixel_first, pixel_last, de;
    logic [3:0]  user;

    logic [15:0] a_data;
    logic        a_valid;
    logic        a_m_lf, a_m_ll, a_m_pf, a_m_pl, a_m_de, a_m_valid;
    logic [3:0]  a_m_user;
    logic [15:0] a_m_data;
    logic [16:0] a_m_ss;
    logic [8:0]  a_m_norm;

    logic [23:0] b_data;
    logic        b_valid;
    logic        b_m_lf, b_m_ll, b_m_pf, b_m_pl, b_m_de, b_m_valid;
    logic [0:0]  b_m_user;
    logic [23:0] b_m_data;
    logic [17:0] b_m_ss;
    logic [8:0]  b_m_norm;

    logic [7:0]  c_data;
    logic        c_valid;
    logic        c_m_lf, c_m_ll, c_m_pf, c_m_pl, c_m_de, c_m_valid;
    logic [0:0]  c_m_user;
    logic [7:0]  c_m_data;
    logic [15:0] c_m_ss;
    logic [7:0]  c_m_norm;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [15:0] data;
        logic [16:0] ss;
        logic [8:0]  norm;
        logic [8:0]  sb;
        int          stamp;
    } exp_t;

    exp_t exp_q[$];

    jelly_img_vec_norm #(
        .USER_WIDTH(4), .CHANNELS(2), .DATA_WIDTH(8), .USE_VALID(1), .USE_SQRT(1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .cke(cke),
        .s_img_line_first(line_first), .s_img_line_last(line_last),
        .s_img_pixel_first(pixel_first), .s_img_pixel_last(pixel_last),
        .s_img_de(de), .s_img_user(user), .s_img_data(a_data), .s_img_valid(a_valid),
        .m_img_line_first(a_m_lf), .m_img_line_last(a_m_ll),
        .m_img_pixel_first(a_m_pf), .m_img_pixel_last(a_m_pl),
        .m_img_de(a_m_de), .m_img_user(a_m_user), .m_img_data(a_m_data),
        .m_img_ss(a_m_ss), .m_img_norm(a_m_norm), .m_img_valid(a_m_valid)
    );

    jelly_img_vec_norm #(
        .USER_WIDTH(0), .CHANNELS(3), .DATA_WIDTH(8), .USE_VALID(1), .USE_SQRT(0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .cke(cke),
        .s_img_line_first(line_first), .s_img_line_last(line_last),
        .s_img_pixel_first(pixel_first), .s_img_pixel_last(pixel_last),
        .s_img_de(de), .s_img_user(user[0:0]), .s_img_data(b_data), .s_img_valid(b_valid),
        .m_img_line_first(b_m_lf), .m_img_line_last(b_m_ll),
        .m_img_pixel_first(b_m_pf), .m_img_pixel_last(b_m_pl),
        .m_img_de(b_m_de), .m_img_user(b_m_user), .m_img_data(b_m_data),
        .m_img_ss(b_m_ss), .m_img_norm(b_m_norm), .m_img_valid(b_m_valid)
    );

    jelly_img_vec_norm #(
        .USER_WIDTH(0), .CHANNELS(1), .DATA_WIDTH(8), .USE_VALID(1), .USE_SQRT(1)
    ) u_dut_c (
        .clk(clk), .reset(reset), .cke(cke),
        .s_img_line_first(line_first), .s_img_line_last(line_last),
        .s_img_pixel_first(pixel_first), .s_img_pixel_last(pixel_last),
        .s_img_de(de), .s_img_user(user[0:0]), .s_img_data(c_data), .s_img_valid(c_valid),
        .m_img_line_first(c_m_lf), .m_img_line_last(c_m_ll),
        .m_img_pixel_first(c_m_pf), .m_img_pixel_last(c_m_pl),
        .m_img_de(c_m_de), .m_img_user(c_m_user), .m_img_data(c_m_data),
        .m_img_ss(c_m_ss), .m_img_norm(c_m_norm), .m_img_valid(c_m_valid)
    );

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int sumsq2(input logic [15:0] d);
        int x0;
        int x1;
        x0 = $signed(d[7:0]);
        x1 = $signed(d[15:8]);
        return x0 * x0 + x1 * x1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every cke=1 edge that shows a valid output retires the oldest entry.
    task automatic checkOutput();
        exp_t e;
        if (a_m_valid) begin
            check("a_output_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("a_latency", 32'(edge_cnt - e.stamp), 32'(A_LAT));
                check("a_ss", 32'(a_m_ss), 32'(e.ss));
                check("a_norm", 32'(a_m_norm), 32'(e.norm));
                check("a_data", 32'(a_m_data), 32'(e.data));
                check("a_sideband", 32'({a_m_user, a_m_de, a_m_pl, a_m_pf, a_m_ll, a_m_lf}),
                      32'(e.sb));
            end
        end
    endtask

    task automatic tick();
        logic was_cke;
        logic was_reset;
        @(posedge clk);
        was_cke   = cke;
        was_reset = reset;
        #1;
        if (was_reset) begin
            exp_q.delete();
        end else if (was_cke) begin
            edge_cnt++;
            checkOutput();
        end
    endtask

    task automatic applyStimulus(input logic [15:0] data, input logic valid,
                                 input logic cke_in, input logic [8:0] sb);
        exp_t e;
        int   ss;
        a_data  = data;
        a_valid = valid;
        cke     = cke_in;
        {user, de, pixel_last, pixel_first, line_last, line_first} = sb;
        if (cke_in && valid && !reset) begin
            ss      = sumsq2(data);
            e.data  = data;
            e.ss    = 17'(ss);
            e.norm  = 9'(isqrt(ss));
            e.sb    = sb;
            e.stamp = edge_cnt;
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic drain();
        repeat (A_LAT + 3) applyStimulus(16'h0, 1'b0, 1'b1, 9'h0);
        check("a_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int b_lat;
        int c_lat;
        logic [17:0] b_ss_cap;
        logic [8:0]  b_norm_cap;
        logic [23:0] b_data_cap;
        logic [15:0] c_ss_cap;
        logic [7:0]  c_norm_cap;
        logic [7:0]  c_data_cap;
        logic [4:0]  c_flags_cap;

        reset   = 1'b1;
        cke     = 1'b1;
        b_data  = '0;
        b_valid = 1'b0;
        c_data  = '0;
        c_valid = 1'b0;
        applyStimulus(16'h0, 1'b0, 1'b1, 9'h0);
        applyStimulus(16'h0, 1'b0, 1'b1, 9'h0);
        reset = 1'b0;

        check("reset_a_ss", 32'(a_m_ss), 32'd0);
        check("reset_a_norm", 32'(a_m_norm), 32'd0);
        check("reset_a_data", 32'(a_m_data), 32'd0);
        check("reset_a_valid", 32'(a_m_valid), 32'd0);
        check("reset_a_de", 32'(a_m_de), 32'd0);
        check("reset_b_ss", 32'(b_m_ss), 32'd0);
        check("reset_c_norm", 32'(c_m_norm), 32'd0);

        $display("[TB] directed corner pixels");
        applyStimulus({8'd4, 8'd3}, 1'b1, 1'b1, 9'b0000_10000);
        applyStimulus({8'h80, 8'h80}, 1'b1, 1'b1, 9'b0101_10101);
        applyStimulus({8'h7F, 8'h80}, 1'b1, 1'b1, 9'b1010_11010);
        applyStimulus({8'h00, 8'h00}, 1'b1, 1'b1, 9'b0000_10000);
        drain();

        $display("[TB] random stream with cke gaps");
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(16'($urandom), $urandom_range(0, 7) != 0,
                          $urandom_range(0, 3) != 0, 9'($urandom));
        end
        drain();

        $display("[TB] reset with pixels in flight");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'($urandom), 1'b1, 1'b1, 9'($urandom) | 9'h010);
        end
        reset = 1'b1;
        applyStimulus(16'($urandom), 1'b1, 1'b1, 9'h1FF);
        check("midreset_a_ss", 32'(a_m_ss), 32'd0);
        check("midreset_a_norm", 32'(a_m_norm), 32'd0);
        check("midreset_a_data", 32'(a_m_data), 32'd0);
        check("midreset_a_valid", 32'(a_m_valid), 32'd0);
        check("midreset_a_sideband",
              32'({a_m_user, a_m_de, a_m_pl, a_m_pf, a_m_ll, a_m_lf}), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'($urandom), 1'b1, 1'b1, 9'($urandom));
        end
        drain();

        $display("[TB] three-channel and single-channel instances");
        b_lat   = -1;
        c_lat   = -1;
        b_ss_cap = '0; b_norm_cap = '0; b_data_cap = '0;
        c_ss_cap = '0; c_norm_cap = '0; c_data_cap = '0; c_flags_cap = '0;
        b_data  = {8'h02, 8'hFE, 8'h01};
        b_valid = 1'b1;
        c_data  = 8'hF9;
        c_valid = 1'b1;
        applyStimulus(16'h0, 1'b0, 1'b1, 9'b0000_00110);
        b_valid = 1'b0;
        c_valid = 1'b0;
        b_data  = '0;
        c_data  = '0;
        for (int cyc = 2; cyc <= 20; cyc++) begin
            applyStimulus(16'h0, 1'b0, 1'b1, 9'h0);
            if (b_m_valid && b_lat < 0) begin
                b_lat = cyc; b_ss_cap = b_m_ss; b_norm_cap = b_m_norm; b_data_cap = b_m_data;
            end
            if (c_m_valid && c_lat < 0) begin
                c_lat = cyc; c_ss_cap = c_m_ss; c_norm_cap = c_m_norm; c_data_cap = c_m_data;
                c_flags_cap = {c_m_de, c_m_pl, c_m_pf, c_m_ll, c_m_lf};
            end
        end
        check("b_latency", 32'(b_lat), 32'(B_LAT));
        check("b_ss", 32'(b_ss_cap), 32'd9);
        check("b_norm", 32'(b_norm_cap), 32'd0);
        check("b_data", 32'(b_data_cap), 32'h02FE01);
        check("c_latency", 32'(c_lat), 32'(C_LAT));
        check("c_ss", 32'(c_ss_cap), 32'd49);
        check("c_norm", 32'(c_norm_cap), 32'd7);
        check("c_data", 32'(c_data_cap), 32'hF9);
        check("c_flags", 32'(c_flags_cap), 32'b00110);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
